phase_burst_scheduler: RTL and testbench

//  Shares the 4-phase pulse resource (one-hot phases PH1..PH4, one per CLK, 4-cycle frame) between

---
 rtl/phase_burst_scheduler_pkg.sv | 18 +
 rtl/phase_burst_scheduler_if.sv | 28 ++
 rtl/phase_burst_scheduler_rr_arbiter4.sv | 23 ++
 rtl/phase_burst_scheduler.sv | 116 +++++++++++
 tb/tb_phase_burst_scheduler.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/phase_burst_scheduler_pkg.sv
// Shared types and helpers for the phase burst scheduler: FSM state encoding,
// phase count and a one-hot decoder for the four-phase frame.
package phase_burst_scheduler_pkg;

  localparam int unsigned NUM_PH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  function automatic logic [NUM_PH-1:0] onehot4(input logic [1:0] idx);
    onehot4      = '0;
    onehot4[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/phase_burst_scheduler_if.sv
// Request/override inputs and phase/grant outputs of the phase burst scheduler.
interface phase_burst_scheduler_if
  import phase_burst_scheduler_pkg::*;
#(
  parameter int unsigned LEN_W = 8
);

  logic [NUM_PH-1:0]       REQ;
  logic [NUM_PH*LEN_W-1:0] REQ_LEN;
  logic                    FORCE;
  logic                    MUTE;
  logic [NUM_PH-1:0]       PH;
  logic [NUM_PH-1:0]       OUT;
  logic [NUM_PH-1:0]       GNT;
  logic [NUM_PH-1:0]       DONE;
  logic                    BUSY;

  modport master (
    output REQ, REQ_LEN, FORCE, MUTE,
    input  PH, OUT, GNT, DONE, BUSY
  );

  modport slave (
    input  REQ, REQ_LEN, FORCE, MUTE,
    output PH, OUT, GNT, DONE, BUSY
  );

endinterface

// File: rtl/phase_burst_scheduler_rr_arbiter4.sv
// Combinational 4-way round-robin pick: first set request after rr_last, wrapping.
module rr_arbiter4
  import phase_burst_scheduler_pkg::*;
(
  input  logic [NUM_PH-1:0] req,
  input  logic [1:0]        rr_last,
  output logic [1:0]        winner,
  output logic              valid
);

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    // 2-bit sum wraps mod 4; i==4 lands back on rr_last as lowest priority
    for (int unsigned i = 1; i <= NUM_PH; i++) begin
      if (!valid && req[rr_last + 2'(i)]) begin
        valid  = 1'b1;
        winner = rr_last + 2'(i);
      end
    end
  end

endmodule

// File: rtl/phase_burst_scheduler.sv
// Free-running 4-phase frame generator shared round-robin between four requesters,
// playing whole-frame bursts separated by a guard gap, with FORCE/MUTE output gating.
module phase_burst_scheduler
  import phase_burst_scheduler_pkg::*;
#(
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned GUARD_CYC = 4
)(
  input logic                CLK,
  input logic                RST,
  phase_burst_scheduler_if.slave bus
);

  localparam int unsigned GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

  state_t            state, state_n;
  logic [1:0]        ph_cnt;
  logic [1:0]        rr_last, rr_last_n;
  logic [LEN_W-1:0]  frame_cnt, frame_cnt_n;
  logic [GW-1:0]     guard_cnt, guard_cnt_n;
  logic [NUM_PH-1:0] gnt, gnt_n;
  logic [NUM_PH-1:0] done, done_n;
  logic [NUM_PH-1:0] out;
  logic [1:0]        win;
  logic              win_valid;
  logic [LEN_W-1:0]  len_sel;

  rr_arbiter4 u_arb (
    .req     (bus.REQ),
    .rr_last (rr_last),
    .winner  (win),
    .valid   (win_valid)
  );

  assign len_sel = bus.REQ_LEN[win*LEN_W +: LEN_W];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ph_cnt <= '0;
    else     ph_cnt <= ph_cnt + 2'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      rr_last   <= 2'd3;
      frame_cnt <= '0;
      guard_cnt <= '0;
      gnt       <= '0;
      done      <= '0;
    end else begin
      state     <= state_n;
      rr_last   <= rr_last_n;
      frame_cnt <= frame_cnt_n;
      guard_cnt <= guard_cnt_n;
      gnt       <= gnt_n;
      done      <= done_n;
    end
  end

  // rr_last doubles as the index of the current burst owner while in RUN
  always_comb begin
    state_n     = state;
    rr_last_n   = rr_last;
    frame_cnt_n = frame_cnt;
    guard_cnt_n = guard_cnt;
    gnt_n       = gnt;
    done_n      = '0;
    case (state)
      ST_IDLE: begin
        if (ph_cnt == 2'd3 && win_valid) begin
          rr_last_n = win;
          if (len_sel != '0) begin
            gnt_n       = onehot4(win);
            frame_cnt_n = len_sel - LEN_W'(1);
            state_n     = ST_RUN;
          end else begin
            done_n      = onehot4(win);
            guard_cnt_n = GW'(GUARD_CYC - 1);
            state_n     = ST_GUARD;
          end
        end
      end
      ST_RUN: begin
        if (ph_cnt == 2'd3) begin
          if (frame_cnt == '0) begin
            gnt_n       = '0;
            done_n      = onehot4(rr_last);
            guard_cnt_n = GW'(GUARD_CYC - 1);
            state_n     = ST_GUARD;
          end else begin
            frame_cnt_n = frame_cnt - LEN_W'(1);
          end
        end
      end
      ST_GUARD: begin
        if (guard_cnt == '0) state_n = ST_IDLE;
        else                 guard_cnt_n = guard_cnt - GW'(1);
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    out = '0;
    if (bus.FORCE)            out = '1;
    else if (bus.MUTE)        out = '0;
    else if (state == ST_RUN) out = onehot4(ph_cnt);
  end

  assign bus.PH   = onehot4(ph_cnt);
  assign bus.OUT  = out;
  assign bus.GNT  = gnt;
  assign bus.DONE = done;
  assign bus.BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_phase_burst_scheduler.sv
// Directed self-checking bench for phase_burst_scheduler (LEN_W=8, GUARD_CYC=4).
module tb_phase_burst_scheduler;

  logic CLK;
  logic RST;
  int   n_assert;
  int   n_fail;
  int   ph;

  phase_burst_scheduler_if #(.LEN_W(8)) bus ();

  phase_burst_scheduler #(
    .LEN_W     (8),
    .GUARD_CYC (4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [3:0] tb_oh(input int p);
    tb_oh = 4'(1 << p);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    ph = (ph + 1) % 4;
  endtask

  task automatic wait_ph(input int n);
    for (int i = 0; i < 4 && ph != n; i++) step();
  endtask

  task automatic pulse_reset();
    #1 RST = 1'b1;
    #1;
    chk("rst_ph", 32'(bus.PH), 32'h1);
    chk("rst_gnt", 32'(bus.GNT), 32'h0);
    chk("rst_busy", 32'(bus.BUSY), 32'h0);
    chk("rst_done", 32'(bus.DONE), 32'h0);
    chk("rst_out", 32'(bus.OUT), 32'h0);
    #1 RST = 1'b0;
    ph = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    ph          = 0;
    RST         = 1'b1;
    bus.REQ     = '0;
    bus.REQ_LEN = '0;
    bus.FORCE   = 1'b0;
    bus.MUTE    = 1'b0;

    // reset state, FORCE honoured even in reset
    #3;
    chk("r_ph", 32'(bus.PH), 32'h1);
    chk("r_out", 32'(bus.OUT), 32'h0);
    chk("r_gnt", 32'(bus.GNT), 32'h0);
    chk("r_done", 32'(bus.DONE), 32'h0);
    chk("r_busy", 32'(bus.BUSY), 32'h0);
    bus.FORCE = 1'b1;
    #1;
    chk("r_force", 32'(bus.OUT), 32'hF);
    bus.FORCE = 1'b0;
    #4 RST = 1'b0;

    // 1: free-running phases, idle outputs
    #1;
    chk("t1_ph0", 32'(bus.PH), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t1_ph", 32'(bus.PH), 32'(tb_oh(i % 4)));
      chk("t1_out", 32'(bus.OUT), 32'h0);
      chk("t1_busy", 32'(bus.BUSY), 32'h0);
    end

    // 2: single burst, requester 0, two frames
    bus.REQ     = 4'b0001;
    bus.REQ_LEN = {8'd0, 8'd0, 8'd0, 8'd2};
    wait_ph(3);
    chk("t2_pregnt", 32'(bus.GNT), 32'h0);
    chk("t2_prebusy", 32'(bus.BUSY), 32'h0);
    step();
    bus.REQ = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      chk("t2_out", 32'(bus.OUT), 32'(tb_oh(ph)));
      chk("t2_gnt", 32'(bus.GNT), 32'h1);
      chk("t2_done0", 32'(bus.DONE), 32'h0);
      step();
    end
    chk("t2_done", 32'(bus.DONE), 32'h1);
    chk("t2_gntoff", 32'(bus.GNT), 32'h0);
    chk("t2_outoff", 32'(bus.OUT), 32'h0);
    step();
    chk("t2_done1cyc", 32'(bus.DONE), 32'h0);
    step();
    step();
    chk("t2_guard", 32'(bus.BUSY), 32'h1);
    step();
    chk("t2_idle", 32'(bus.BUSY), 32'h0);

    // 3: all four requesting, one frame each, from reset priority
    pulse_reset();
    bus.REQ     = 4'b1111;
    bus.REQ_LEN = {8'd1, 8'd1, 8'd1, 8'd1};
    for (int j = 0; j < 5; j++) begin
      wait_ph(3);
      chk("t3_pregnt", 32'(bus.GNT), 32'h0);
      step();
      chk("t3_gnt", 32'(bus.GNT), 32'(tb_oh(j % 4)));
      chk("t3_out", 32'(bus.OUT), 32'h1);
      step();
      step();
      step();
      chk("t3_gnthold", 32'(bus.GNT), 32'(tb_oh(j % 4)));
      step();
      chk("t3_done", 32'(bus.DONE), 32'(tb_oh(j % 4)));
      chk("t3_gntoff", 32'(bus.GNT), 32'h0);
      step();
      step();
      step();
      chk("t3_guard", 32'(bus.BUSY), 32'h1);
      chk("t3_guardgnt", 32'(bus.GNT), 32'h0);
      step();
      chk("t3_idle", 32'(bus.BUSY), 32'h0);
    end
    bus.REQ = 4'b0000;

    // 4: zero-length request from requester 2
    bus.REQ     = 4'b0100;
    bus.REQ_LEN = {8'd7, 8'd0, 8'd7, 8'd7};
    wait_ph(3);
    step();
    bus.REQ = 4'b0000;
    chk("t4_gnt", 32'(bus.GNT), 32'h0);
    chk("t4_out", 32'(bus.OUT), 32'h0);
    chk("t4_done", 32'(bus.DONE), 32'h4);
    chk("t4_busy", 32'(bus.BUSY), 32'h1);
    step();
    chk("t4_done1cyc", 32'(bus.DONE), 32'h0);
    chk("t4_out1", 32'(bus.OUT), 32'h0);
    step();
    step();
    chk("t4_guard", 32'(bus.BUSY), 32'h1);
    step();
    chk("t4_idle", 32'(bus.BUSY), 32'h0);

    // 5: three-frame burst for requester 1, muted in the middle frame
    bus.REQ     = 4'b0010;
    bus.REQ_LEN = {8'd9, 8'd9, 8'd3, 8'd9};
    wait_ph(3);
    step();
    bus.REQ = 4'b0000;
    chk("t5_gnt", 32'(bus.GNT), 32'h2);
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < 4; p++) begin
        bus.MUTE = (f == 1);
        #1;
        chk("t5_out", 32'(bus.OUT), (f == 1) ? 32'h0 : 32'(tb_oh(p)));
        chk("t5_done0", 32'(bus.DONE), 32'h0);
        step();
      end
    end
    bus.MUTE = 1'b0;
    chk("t5_done", 32'(bus.DONE), 32'h2);
    step();
    step();
    step();
    step();
    chk("t5_idle", 32'(bus.BUSY), 32'h0);
    bus.FORCE = 1'b1;
    #1;
    chk("t5_force", 32'(bus.OUT), 32'hF);
    bus.FORCE = 1'b0;
    #1;
    chk("t5_unforce", 32'(bus.OUT), 32'h0);

    // 6: reset in the middle of a burst
    bus.REQ     = 4'b0001;
    bus.REQ_LEN = {8'd2, 8'd2, 8'd2, 8'd5};
    wait_ph(3);
    step();
    bus.REQ = 4'b0000;
    chk("t6_gnt", 32'(bus.GNT), 32'h1);
    for (int i = 0; i < 5; i++) step();
    chk("t6_busy", 32'(bus.BUSY), 32'h1);
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t6_nodone", 32'(bus.DONE), 32'h0);
      chk("t6_nognt", 32'(bus.GNT), 32'h0);
      chk("t6_ph", 32'(bus.PH), 32'(tb_oh(ph)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
